// File: rtl/cpu_trace_pkg.sv
// Shared types and entry-layout helpers for the CPU debug trace buffer.
// An entry is packed as {timestamp, flag, ch_data}, with channel 0 at the LSBs.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STOPPED = 2'd2
    } state_t;

    localparam int DATA_LSB = 0;

    function automatic int entry_w(input int ts_w, input int num_ch, input int data_w);
        return ts_w + 1 + num_ch * data_w;
    endfunction

    function automatic int flag_pos(input int num_ch, input int data_w);
        return num_ch * data_w;
    endfunction

    function automatic int ts_lsb(input int num_ch, input int data_w);
        return num_ch * data_w + 1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with an exact occupancy count.
// When evict_when_full is set, a push into a full FIFO that has no pop overwrites the oldest entry.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     evict_when_full,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_pop, do_push, evict;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    assign evict   = push && full && !do_pop && evict_when_full;
    assign do_push = push && (!full || do_pop || evict_when_full);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop || evict)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop) - (AW+1)'(evict);
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the pointers
    // and count, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trace capture of CPU watch channels with a timestamp per entry and a valid/ready drain port.
// Define TRACE_WRAP_EN to overwrite the oldest entry on overflow instead of dropping the newest.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 16,
    parameter int TS_W        = 16,
    parameter int STOP_CYCLES = 50
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       mode,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic                       flag_in,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [TS_W-1:0]            rd_ts,
    output logic                       rd_flag,
    output logic [NUM_CH*DATA_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       capturing,
    output logic                       stopped
);
    localparam int CH_W    = NUM_CH * DATA_W;
    localparam int ENTRY_W = entry_w(TS_W, NUM_CH, DATA_W);
    localparam int FLAG_P  = flag_pos(NUM_CH, DATA_W);
    localparam int TS_L    = ts_lsb(NUM_CH, DATA_W);

`ifdef TRACE_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [TS_W-1:0]   cyc_cnt;
    logic [CH_W:0]     prev, sample;
    logic              prev_valid, mode_q, overflow_q;
    logic              capture, pop_fire, lost, fifo_full, fifo_empty, last_cycle;
    logic [ENTRY_W-1:0] wentry, rentry;

    assign sample     = {flag_in, ch_data};
    assign last_cycle = (cyc_cnt == TS_W'(STOP_CYCLES - 1));
    assign capture    = (state_q == CAPTURE) && (mode_q || !prev_valid || sample != prev);
    assign pop_fire   = !fifo_empty && rd_ready;
    assign lost       = capture && fifo_full && !pop_fire;
    assign wentry     = {cyc_cnt, flag_in, ch_data};

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        capturing = 1'b0;
        stopped   = 1'b0;
        unique case (state_q)
            IDLE:    if (arm) state_d = CAPTURE;
            CAPTURE: begin
                capturing = 1'b1;
                if (arm)             state_d = CAPTURE;
                else if (last_cycle) state_d = STOPPED;
            end
            STOPPED: begin
                stopped = 1'b1;
                if (arm) state_d = CAPTURE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cyc_cnt    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            mode_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Arm opens a fresh window but leaves earlier entries readable.
            if (arm) begin
                cyc_cnt    <= '0;
                prev_valid <= 1'b0;
                overflow_q <= 1'b0;
                mode_q     <= mode;
            end else if (state_q == CAPTURE) begin
                cyc_cnt    <= cyc_cnt + 1'b1;
                prev       <= sample;
                prev_valid <= 1'b1;
                if (lost)
                    overflow_q <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .push            (capture),
        .pop             (rd_ready),
        .evict_when_full (WRAP),
        .wdata           (wentry),
        .rdata           (rentry),
        .full            (fifo_full),
        .empty           (fifo_empty),
        .count           (count)
    );

    assign rd_valid = !fifo_empty;
    assign rd_ts    = rentry[TS_L +: TS_W];
    assign rd_flag  = rentry[FLAG_P];
    assign rd_data  = rentry[DATA_LSB +: CH_W];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer with default parameters.
// Expected head/tail timestamps depend on whether TRACE_WRAP_EN is defined.
module tb_cpu_trace_buffer;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;

`ifdef TRACE_WRAP_EN
    localparam int FULL_HEAD = 34;
`else
    localparam int FULL_HEAD = 0;
`endif

    logic                      clk = 1'b0;
    logic                      rst, arm, mode, flag_in, rd_ready;
    logic [NUM_CH*DATA_W-1:0]  ch_data;
    logic                      rd_valid, rd_flag, overflow, capturing, stopped;
    logic [TS_W-1:0]           rd_ts;
    logic [NUM_CH*DATA_W-1:0]  rd_data;
    logic [$clog2(DEPTH):0]    count;

    int n_cmp = 0;
    int n_bad = 0;
    int max_cnt;
    int exp_ts [3] = '{0, 3, 7};
    int exp_d0 [3] = '{0, 4, 8};

    always #5 clk = ~clk;

    cpu_trace_buffer #(
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .DEPTH       (DEPTH),
        .TS_W        (TS_W),
        .STOP_CYCLES (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .mode      (mode),
        .ch_data   (ch_data),
        .flag_in   (flag_in),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_ts     (rd_ts),
        .rd_flag   (rd_flag),
        .rd_data   (rd_data),
        .count     (count),
        .overflow  (overflow),
        .capturing (capturing),
        .stopped   (stopped)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pop_one;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; mode = 1'b0; flag_in = 1'b0; rd_ready = 1'b0;
        ch_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0};
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("reset rd_valid",  64'(rd_valid),  64'd0);
        check("reset count",     64'(count),     64'd0);
        check("reset capturing", 64'(capturing), 64'd0);
        check("reset stopped",   64'(stopped),   64'd0);
        check("reset overflow",  64'(overflow),  64'd0);

        // Change mode: ch0 steps at window cycles 3 and 7.
        mode = 1'b0; arm = 1'b1; tick(); arm = 1'b0;
        check("arm capturing", 64'(capturing), 64'd1);
        for (int k = 0; k < 50; k++) begin
            ch_data[31:0] = (k >= 7) ? 32'd8 : (k >= 3) ? 32'd4 : 32'd0;
            tick();
        end
        check("chg stopped",   64'(stopped),   64'd1);
        check("chg capturing", 64'(capturing), 64'd0);
        check("chg count",     64'(count),     64'd3);
        for (int i = 0; i < 3; i++) begin
            check("chg rd_valid", 64'(rd_valid),       64'd1);
            check("chg rd_ts",    64'(rd_ts),          64'(exp_ts[i]));
            check("chg ch0",      64'(rd_data[31:0]),  64'(exp_d0[i]));
            check("chg ch3",      64'(rd_data[127:96]), 64'h3333_3333);
            pop_one();
        end
        check("chg drained", 64'(rd_valid), 64'd0);

        // Cycle mode with no reader: fills and overflows.
        mode = 1'b1; flag_in = 1'b1; arm = 1'b1; tick(); arm = 1'b0;
        repeat (50) tick();
        flag_in = 1'b0;
        check("full count",    64'(count),    64'd16);
        check("full overflow", 64'(overflow), 64'd1);
        check("full flag",     64'(rd_flag),  64'd1);
        for (int i = 0; i < 16; i++) begin
            check("full rd_ts", 64'(rd_ts), 64'(FULL_HEAD + i));
            pop_one();
        end
        check("full drained", 64'(count), 64'd0);

        // Cycle mode with reader always ready: stream in order.
        rd_ready = 1'b1; arm = 1'b1; tick(); arm = 1'b0;
        max_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            check("stream rd_valid", 64'(rd_valid), 64'd1);
            check("stream rd_ts",    64'(rd_ts),    64'(k));
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        tick();
        rd_ready = 1'b0;
        check("stream max count", 64'(max_cnt),  64'd1);
        check("stream empty",     64'(count),    64'd0);
        check("stream overflow",  64'(overflow), 64'd0);

        // Full FIFO with capture and pop in the same cycle.
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (16) tick();
        check("fp pre count",    64'(count),    64'd16);
        check("fp pre overflow", 64'(overflow), 64'd0);
        check("fp pre head",     64'(rd_ts),    64'd0);
        pop_one();
        check("fp count",    64'(count),    64'd16);
        check("fp overflow", 64'(overflow), 64'd0);
        check("fp head",     64'(rd_ts),    64'd1);

        // Restart mid-window, then reset at window cycle 20.
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (20) tick();
        check("rst pre overflow",  64'(overflow),  64'd1);
        check("rst pre capturing", 64'(capturing), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst count",     64'(count),     64'd0);
        check("rst rd_valid",  64'(rd_valid),  64'd0);
        check("rst capturing", 64'(capturing), 64'd0);
        check("rst overflow",  64'(overflow),  64'd0);
        arm = 1'b1; tick(); arm = 1'b0;
        check("rearm empty", 64'(rd_valid), 64'd0);
        tick();
        check("rearm rd_valid", 64'(rd_valid), 64'd1);
        check("rearm rd_ts",    64'(rd_ts),    64'd0);
        check("rearm count",    64'(count),    64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Synthesizable, parametrised trace capture for CPU_TOP debug signals.
- Samples NUM_CH watch channels (e.g. PC, Inst, ALU_Out, R1) plus one flag bit (Zero).
- In change mode, logs an entry only when a watched value changes; in cycle mode, logs every cycle. Each entry carries a cycle timestamp.
- Stops itself after a programmable number of cycles.
- Entries drain through a valid/ready read port, so on-chip self-check and FPGA bring-up no longer depend on simulator printouts.

Parameters:
DATA_W, 32, width of one watch channel
NUM_CH, 4, number of watch channels
DEPTH, 16, trace entries stored; power of two, at least 2
TS_W, 16, timestamp/cycle counter width
STOP_CYCLES, 50, capture window length in cycles; 1 to 2^TS_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
arm  in  1  one-cycle pulse: start/restart capture
mode  in  1  0 = capture on change, 1 = capture every cycle; sampled at arm
ch_data  in  NUM_CH*DATA_W  watch channels, channel k at bits [k*DATA_W +: DATA_W]
flag_in  in  1  watched flag (Zero)
rd_ready  in  1  consumer accepts head entry
rd_valid  out  1  head entry present
rd_ts  out  TS_W  head entry timestamp
rd_flag  out  1  head entry flag
rd_data  out  NUM_CH*DATA_W  head entry channel data
count  out  $clog2(DEPTH)+1  entries stored
overflow  out  1  sticky: at least one sample lost or overwritten
capturing  out  1  state == CAPTURE
stopped  out  1  state == STOPPED

Behaviour:
- Reset values: state IDLE, FIFO empty, count 0, rd_valid 0, overflow 0, cycle counter 0, previous-sample register invalid.
- States:
  - IDLE: arm -> CAPTURE.
  - CAPTURE: when cycle counter == STOP_CYCLES-1 -> STOPPED, after processing the sample for that cycle.
  - STOPPED: arm -> CAPTURE.
- Entering CAPTURE (the cycle after arm):
  - cycle counter = 0, overflow = 0, prev invalid, mode latched.
  - FIFO contents are kept; entries from an earlier window remain readable.
- Arm while already in CAPTURE restarts the window with the same clearing rules.
- Capture decision, every CAPTURE cycle, with sample = {flag_in, ch_data}:
  - capture when mode == 1, or prev is invalid, or sample != prev;
  - prev <= sample every CAPTURE cycle.
- Entry = {cycle counter, flag_in, ch_data}. The cycle counter increments every CAPTURE cycle.
- Latency: a sample taken at edge N gives rd_valid high in cycle N+1 if the FIFO was empty.
- Read port is first-word fall-through:
  - rd_* show the head entry whenever rd_valid == 1;
  - a pop occurs on (rd_valid && rd_ready);
  - rd_* are don't-care when rd_valid == 0.
- Full FIFO with capture and no pop: the new entry is dropped, overflow <= 1, count stays DEPTH.
- Full FIFO with capture and pop in the same cycle: both proceed, count unchanged, no overflow.
- Empty FIFO with capture and rd_ready: rd_valid was 0, so no pop; the entry is written.
- Pointers wrap modulo DEPTH. count is exact, 0..DEPTH.
- Reads are allowed in every state. No captures occur in IDLE or STOPPED.
- rst during CAPTURE: everything returns to reset values the next edge; the FIFO is emptied.

Optional Feature:
TRACE_WRAP_EN
- Defined: full FIFO with capture and no pop overwrites the oldest entry (head advances, new entry written), overflow <= 1, count stays DEPTH. Full FIFO with capture and pop behaves as in the base case.
- Undefined: drop-newest behaviour as described above.

Decomposition:
- Package cpu_trace_pkg holds:
  - state enum {IDLE, CAPTURE, STOPPED};
  - ENTRY_W = TS_W+1+NUM_CH*DATA_W as a function of the parameters;
  - field offset constants for ts/flag/data within an entry.
- One sub-module, trace_fifo: synchronous FWFT FIFO, parametrised by width and depth, with push/pop/full/empty/count. The wrap option is passed through as a push-when-full-evicts input.

Test Plan:
- Reset then idle for 10 cycles -> rd_valid=0, count=0, capturing=0, stopped=0, overflow=0.
- Mode 0, arm, hold ch_data constant, change ch0 0x0->0x4 at window cycles 3 and 7 (values 0x4, then 0x8) -> 3 entries with rd_ts 0, 3, 7; stopped=1 after 50 CAPTURE cycles.
- Mode 1, DEPTH=16, STOP_CYCLES=50, rd_ready=0 -> count saturates at 16 with rd_ts 0..15 and overflow=1. With TRACE_WRAP_EN, the head rd_ts is 34 and the tail is 49.
- Mode 1, rd_ready=1 throughout -> every cycle popped, count stays at most 1, overflow=0, rd_ts stream 0,1,...,49 in order.
- Full FIFO with simultaneous capture and pop -> count stays 16, overflow stays 0, the next rd_ts is the old head plus 1.
- Pulse rst at window cycle 20 of mode 1 -> next cycle: count=0, rd_valid=0, capturing=0. Re-arm -> first entry has rd_ts=0.
